// File: rtl/register_file_mp_if.sv
// Register-file port bundle: read addr/data/busy, write ports and scoreboard claim.
// master = decode/writeback side, slave = register file.
interface register_file_mp_if #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 1
);
   localparam int AW = $clog2(NREGS);

   logic [NUM_RD*AW-1:0]   rd_addr;
   logic [NUM_RD*XLEN-1:0] rd_data;
   logic [NUM_RD-1:0]      rd_busy;
   logic [NUM_WR-1:0]      wr_en;
   logic [NUM_WR*AW-1:0]   wr_addr;
   logic [NUM_WR*XLEN-1:0] wr_data;
   logic                   claim_en;
   logic [AW-1:0]          claim_addr;
   logic [NREGS-1:0]       busy_vec;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
      input  rd_data, rd_busy, busy_vec
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
      output rd_data, rd_busy, busy_vec
   );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port register file + busy scoreboard; zero-latency reads, writes/claims land on the clock edge, no back-pressure.
// Optional REGFILE_BYPASS_EN forwards same-cycle write data (and busy release) to the read ports.
module register_file_mp #(
   parameter int XLEN      = 32,
   parameter int NREGS     = 32,
   parameter int NUM_RD    = 2,
   parameter int NUM_WR    = 1,
   parameter int ZERO_REG0 = 1
) (
   input  logic                clock,
   input  logic                reset_n,
   register_file_mp_if.slave   bus
);
   localparam int AW     = $clog2(NREGS);
   localparam bit P_ZERO = (ZERO_REG0 != 0);

   logic [XLEN-1:0]        r_mem [NREGS];
   logic [NREGS-1:0]       r_busy;
   logic [NREGS-1:0]       w_busy_nxt;
   logic [NUM_RD*XLEN-1:0] w_rd_data;
   logic [NUM_RD-1:0]      w_rd_busy;
   logic [AW-1:0]          w_addr;
   logic [AW-1:0]          w_waddr;
   logic [XLEN-1:0]        w_data;
   logic                   w_busy;
`ifdef REGFILE_BYPASS_EN
   logic                   w_hit;
`endif

   // Later ports assign last, so the highest-indexed port wins a collision.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int r = 0; r < NREGS; r++) begin
            r_mem[r] <= '0;
         end
      end else begin
         for (int j = 0; j < NUM_WR; j++) begin
            if (bus.wr_en[j] && !(P_ZERO && (bus.wr_addr[j*AW +: AW] == '0))) begin
               r_mem[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*XLEN +: XLEN];
            end
         end
      end
   end

   // Claim is applied after the clears so a same-cycle claim keeps the register busy.
   always_comb begin
      w_busy_nxt = r_busy;
      w_waddr    = '0;
      for (int j = 0; j < NUM_WR; j++) begin
         w_waddr = bus.wr_addr[j*AW +: AW];
         if (bus.wr_en[j]) begin
            w_busy_nxt[w_waddr] = 1'b0;
         end
      end
      if (bus.claim_en) begin
         w_busy_nxt[bus.claim_addr] = 1'b1;
      end
      if (P_ZERO) begin
         w_busy_nxt[0] = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   always_comb begin
      w_rd_data = '0;
      w_rd_busy = '0;
      w_addr    = '0;
      w_data    = '0;
      w_busy    = 1'b0;
`ifdef REGFILE_BYPASS_EN
      w_hit     = 1'b0;
`endif
      for (int i = 0; i < NUM_RD; i++) begin
         w_addr = bus.rd_addr[i*AW +: AW];
         w_data = r_mem[w_addr];
         w_busy = r_busy[w_addr];
`ifdef REGFILE_BYPASS_EN
         w_hit  = 1'b0;
         for (int j = 0; j < NUM_WR; j++) begin
            if (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] == w_addr)) begin
               w_hit  = 1'b1;
               w_data = bus.wr_data[j*XLEN +: XLEN];
            end
         end
         if (w_hit && !(bus.claim_en && (bus.claim_addr == w_addr))) begin
            w_busy = 1'b0;
         end
`endif
         // Gating on reset_n keeps forwarded data from leaking out while reset is held.
         if ((P_ZERO && (w_addr == '0)) || !reset_n) begin
            w_data = '0;
            w_busy = 1'b0;
         end
         w_rd_data[i*XLEN +: XLEN] = w_data;
         w_rd_busy[i]              = w_busy;
      end
   end

   assign bus.rd_data  = w_rd_data;
   assign bus.rd_busy  = w_rd_busy;
   assign bus.busy_vec = r_busy;

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: directed cases plus randomized traffic against an array model.
module tb_register_file_mp;
   localparam int XLEN   = 32;
   localparam int NREGS  = 32;
   localparam int NUM_RD = 2;
   localparam int NUM_WR = 2;
   localparam int AW     = 5;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   register_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus ();

   register_file_mp #(
      .XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .ZERO_REG0(1)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   logic [XLEN-1:0]  m_mem [NREGS];
   logic [NREGS-1:0] m_busy;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int r = 0; r < NREGS; r++) m_mem[r] = '0;
      m_busy = '0;
   endtask

   // Reference view of a read port: stored value, optionally overridden by a same-cycle write.
   function automatic void model_read(input logic [AW-1:0] a, output logic [XLEN-1:0] d, output logic b);
      d = m_mem[a];
      b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NUM_WR; j++) begin
         if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] == a) begin
            d = bus.wr_data[j*XLEN +: XLEN];
            if (!(bus.claim_en && bus.claim_addr == a)) b = 1'b0;
         end
      end
`endif
      if (a == '0 || !reset_n) begin
         d = '0;
         b = 1'b0;
      end
   endfunction

   task automatic model_edge();
      logic [NREGS-1:0] nb;
      logic [AW-1:0]    a;
      if (!reset_n) begin
         model_clear();
         return;
      end
      nb = m_busy;
      for (int j = 0; j < NUM_WR; j++) begin
         a = bus.wr_addr[j*AW +: AW];
         if (bus.wr_en[j]) begin
            if (a != '0) m_mem[a] = bus.wr_data[j*XLEN +: XLEN];
            nb[a] = 1'b0;
         end
      end
      if (bus.claim_en && bus.claim_addr != '0) nb[bus.claim_addr] = 1'b1;
      m_busy = nb;
   endtask

   task automatic check_outputs();
      logic [XLEN-1:0] d;
      logic            b;
      for (int i = 0; i < NUM_RD; i++) begin
         model_read(bus.rd_addr[i*AW +: AW], d, b);
         check($sformatf("rd_data%0d@%0d", i, bus.rd_addr[i*AW +: AW]), 64'(bus.rd_data[i*XLEN +: XLEN]), 64'(d));
         check($sformatf("rd_busy%0d@%0d", i, bus.rd_addr[i*AW +: AW]), 64'(bus.rd_busy[i]), 64'(b));
      end
      check("busy_vec", 64'(bus.busy_vec), 64'(m_busy));
   endtask

   // Called just after a falling edge with inputs set; returns at the next falling edge.
   task automatic tick();
      #1 check_outputs();
      @(posedge clock);
      model_edge();
      @(negedge clock);
   endtask

   task automatic idle();
      bus.rd_addr    = '0;
      bus.wr_en      = '0;
      bus.wr_addr    = '0;
      bus.wr_data    = '0;
      bus.claim_en   = 1'b0;
      bus.claim_addr = '0;
   endtask

   task automatic set_rd(input int p, input int a);
      bus.rd_addr[p*AW +: AW] = a[AW-1:0];
   endtask

   task automatic set_wr(input int p, input int a, input logic [XLEN-1:0] d);
      bus.wr_en[p]               = 1'b1;
      bus.wr_addr[p*AW +: AW]    = a[AW-1:0];
      bus.wr_data[p*XLEN +: XLEN] = d;
   endtask

   task automatic set_claim(input int a);
      bus.claim_en   = 1'b1;
      bus.claim_addr = a[AW-1:0];
   endtask

   task automatic randomize_inputs(input bit narrow);
      int hi;
      hi = narrow ? 7 : NREGS - 1;
      idle();
      for (int j = 0; j < NUM_WR; j++) begin
         if ($urandom_range(0, 1) == 1) set_wr(j, $urandom_range(0, hi), $urandom());
      end
      for (int i = 0; i < NUM_RD; i++) set_rd(i, $urandom_range(0, hi));
      if ($urandom_range(0, 2) == 0) set_claim($urandom_range(0, hi));
   endtask

   initial begin
      model_clear();
      randomize_inputs(1'b0);

      // Reset held with random inputs: everything reads as zero.
      for (int k = 0; k < 3; k++) begin
         randomize_inputs(1'b0);
         #1;
         check("rst_busy_vec", 64'(bus.busy_vec), 64'd0);
         check("rst_rd_data", 64'(bus.rd_data), 64'd0);
         tick();
      end
      reset_n = 1'b1;
      idle();
      for (int r = 1; r < NREGS; r += 2) begin
         set_rd(0, r);
         set_rd(1, (r + 1) % NREGS);
         tick();
      end

      // Write then read on the other port; register 0 stays zero.
      idle(); set_wr(0, 5, 32'hDEADBEEF); tick();
      idle(); set_rd(1, 5); #1 check("rd5", 64'(bus.rd_data[XLEN +: XLEN]), 64'hDEADBEEF); tick();
      idle(); set_wr(0, 0, 32'h1234); tick();
      idle(); set_rd(0, 0); #1 check("rd0", 64'(bus.rd_data[0 +: XLEN]), 64'd0); tick();

      // Write collision: highest port wins.
      idle(); set_wr(0, 7, 32'h11); set_wr(1, 7, 32'h22); tick();
      idle(); set_rd(0, 7); #1 check("collide7", 64'(bus.rd_data[0 +: XLEN]), 64'h22); tick();

      // Scoreboard set / clear / claim-beats-write / reg 0 claim.
      idle(); set_claim(9); tick();
      idle(); #1 check("claim9", 64'(bus.busy_vec[9]), 64'd1);
      set_wr(0, 9, 32'h99); tick();
      idle(); #1 check("clear9", 64'(bus.busy_vec[9]), 64'd0);
      set_claim(9); set_wr(1, 9, 32'h98); tick();
      idle(); #1 check("claimwr9", 64'(bus.busy_vec[9]), 64'd1);
      set_claim(0); tick();
      idle(); #1 check("claim0", 64'(bus.busy_vec[0]), 64'd0);
      set_wr(0, 9, 32'h97); tick();

      // Same-cycle write while reading a busy register.
      idle(); set_wr(0, 3, 32'h1111); set_claim(3); tick();
      idle(); set_wr(0, 3, 32'hA5A5A5A5); set_rd(0, 3); #1;
`ifdef REGFILE_BYPASS_EN
      check("byp_data", 64'(bus.rd_data[0 +: XLEN]), 64'hA5A5A5A5);
      check("byp_busy", 64'(bus.rd_busy[0]), 64'd0);
`else
      check("nobyp_data", 64'(bus.rd_data[0 +: XLEN]), 64'h1111);
      check("nobyp_busy", 64'(bus.rd_busy[0]), 64'd1);
`endif
      tick();

      // Reset asserted between edges during a write.
      idle(); set_wr(0, 12, 32'hCAFE); set_claim(12); tick();
      idle(); set_wr(0, 12, 32'hBEEF); set_rd(0, 12);
      #2 reset_n = 1'b0;
      model_clear();
      #1;
      check("midrst_busy", 64'(bus.busy_vec), 64'd0);
      check("midrst_rd", 64'(bus.rd_data[0 +: XLEN]), 64'd0);
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      idle(); set_rd(0, 12); #1;
      check("post_rst_rd12", 64'(bus.rd_data[0 +: XLEN]), 64'd0);
      check("post_rst_busy", 64'(bus.busy_vec), 64'd0);
      tick();

      // Randomized traffic, alternating dense and sparse address ranges.
      for (int n = 0; n < 1500; n++) begin
         randomize_inputs(n % 3 != 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
